perf_counter_snapshot_reader: RTL

- Downstream consumer of the per-module 64-bit performance counters.
- On a snapshot request, atomically latches all NUM_COUNTERS counter values into shadow registers in the same cycle.
- Streams the latched values out as 32-bit beats over a valid/ready interface to the chip-level debug/config readout path.
- Keeps a saturating count of snapshot requests dropped because a previous snapshot was still draining.

---
 rtl/perf_counter_snapshot_reader_if.sv | 22 ++
 rtl/perf_counter_snapshot_reader.sv | 102 ++++++++++
 2 files changed

// File: rtl/perf_counter_snapshot_reader_if.sv
// Beat stream carrying latched counter halves from the snapshot reader
// to the chip-level debug/config readout path.
interface perf_counter_snapshot_reader_if #(
    parameter int IDX_W = 3
);
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_hi;
    logic             out_last;

    modport master (
        output out_valid, out_data, out_idx, out_hi, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_hi, out_last,
        output out_ready
    );
endinterface

// File: rtl/perf_counter_snapshot_reader.sv
// Atomically latches all 64-bit performance counters on request and drains
// them as 32-bit beats, counting requests rejected while a drain is active.
module perf_counter_snapshot_reader #(
    parameter int NUM_COUNTERS = 8,
    parameter int IDX_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1,
    parameter int DROP_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_COUNTERS*64-1:0] counter_values,
    input  logic                       snap_req,
    output logic                       snap_busy,
    output logic                       snap_done,
    output logic [DROP_W-1:0]          drop_count,
    perf_counter_snapshot_reader_if.master stream
);

    localparam int                BEAT_W    = IDX_W + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * NUM_COUNTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state;
    logic [NUM_COUNTERS*64-1:0] shadow;
    logic [BEAT_W-1:0]          beat;
    logic [BEAT_W-1:0]          next_beat;
    logic [BEAT_W+4:0]          next_offset;

    // Beats follow the packed word order of the shadow vector, so beat b is
    // simply 32-bit word b of the shadow copy.
    assign next_beat   = beat + 1'b1;
    assign next_offset = {next_beat, 5'b0};
    assign snap_busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            shadow           <= '0;
            beat             <= '0;
            drop_count       <= '0;
            snap_done        <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_idx   <= '0;
            stream.out_hi    <= 1'b0;
            stream.out_last  <= 1'b0;
        end else begin
            if (snap_req && (state != S_IDLE) && (drop_count != {DROP_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (snap_req) begin
                        shadow           <= counter_values;
                        beat             <= '0;
                        stream.out_valid <= 1'b1;
                        stream.out_data  <= counter_values[31:0];
                        stream.out_idx   <= '0;
                        stream.out_hi    <= 1'b0;
                        stream.out_last  <= 1'b0;
                        state            <= S_SEND;
                    end
                end

                // Outputs only advance on a handshake, so a stall holds them.
                S_SEND: begin
                    if (stream.out_ready) begin
                        if (beat == LAST_BEAT) begin
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                            snap_done        <= 1'b1;
                            state            <= S_DONE;
                        end else begin
                            beat            <= next_beat;
                            stream.out_data <= shadow[next_offset +: 32];
                            stream.out_idx  <= next_beat[BEAT_W-1:1];
                            stream.out_hi   <= next_beat[0];
                            stream.out_last <= (next_beat == LAST_BEAT);
                        end
                    end
                end

                S_DONE: begin
                    snap_done <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    snap_done        <= 1'b0;
                    stream.out_valid <= 1'b0;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule
